// File: rtl/fft_out_unload.sv
// Reader side of the FFT output buffer: issues read addresses under a credit limit,
// tracks the fixed read latency and streams samples out through a small skid FIFO.
module fft_out_unload #(
   parameter int LOGPTS = 8,
   parameter int DWIDTH = 32,
   parameter int RD_LAT = 3,
   parameter int BITREV = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frameRdy,
   output logic [LOGPTS-1:0] rA,
   input  logic [DWIDTH-1:0] rdData,
   output logic [DWIDTH-1:0] outData,
   output logic              outValid,
   input  logic              outReady,
   output logic              outFirst,
   output logic              outLast,
   output logic [LOGPTS-1:0] outIdx,
   output logic              busy,
   output logic              done
);
   localparam int FIFO_DEPTH = 2 ** $clog2(RD_LAT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_W = CW'(FIFO_DEPTH);
   localparam logic [LOGPTS-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_reg, state_next;
   logic              pending_reg, pending_next;
   logic [LOGPTS-1:0] ctr_reg, ra_reg, ctr_rev, addr;
   logic              pipe_v_reg   [RD_LAT];
   logic [LOGPTS-1:0] pipe_idx_reg [RD_LAT];
   logic [DWIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [LOGPTS-1:0] mem_idx  [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_reg, rd_ptr_reg, fifo_count, inflight;
   logic [CW:0]       credit_used;
   logic              fifo_empty, issue, pop, wr, start;

   genvar gi;
   generate
      for (gi = 0; gi < LOGPTS; gi++) begin : g_rev
         assign ctr_rev[gi] = ctr_reg[LOGPTS-1-gi];
      end
   endgenerate

   assign addr = (BITREV != 0) ? ctr_rev : ctr_reg;
   assign wr   = pipe_v_reg[RD_LAT-1];

   // A pop this cycle frees a slot, which keeps one issue per cycle in steady state.
   always_comb begin
      fifo_count = wr_ptr_reg - rd_ptr_reg;
      fifo_empty = (fifo_count == '0);
      inflight   = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + {{AW{1'b0}}, pipe_v_reg[i]};
      end
      pop         = !fifo_empty && outReady;
      credit_used = {1'b0, inflight} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
      issue       = (state_reg == RUN) && (credit_used < {1'b0, DEPTH_W});
   end

   always_comb begin
      state_next   = state_reg;
      pending_next = pending_reg;
      done         = 1'b0;
      case (state_reg)
         IDLE: begin
            if (frameRdy || pending_reg) begin
               state_next   = RUN;
               pending_next = 1'b0;
            end
         end
         RUN: begin
            if (issue && (ctr_reg == LAST_IDX)) state_next = DRAIN;
            if (frameRdy) pending_next = 1'b1;
         end
         DRAIN: begin
            if ((inflight == '0) && fifo_empty) begin
               done         = 1'b1;
               pending_next = 1'b0;
               state_next   = (pending_reg || frameRdy) ? RUN : IDLE;
            end else if (frameRdy) begin
               pending_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign start = (state_next == RUN) && (state_reg != RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         pending_reg <= 1'b0;
         ctr_reg     <= '0;
         ra_reg      <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         pending_reg <= pending_next;
         if (start) ctr_reg <= '0;
         else if (issue) ctr_reg <= ctr_reg + 1'b1;
         if (issue) ra_reg <= addr;
         wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, wr};
         rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, pop};
      end
   end

   // Tag pipe mirrors the output buffer latency; the index rides along with the valid bit.
   generate
      for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
         always_ff @(posedge clk or posedge rst) begin
            if (rst) pipe_v_reg[gi] <= 1'b0;
            else pipe_v_reg[gi] <= (gi == 0) ? issue : pipe_v_reg[(gi == 0) ? 0 : gi-1];
         end
         always_ff @(posedge clk) begin
            pipe_idx_reg[gi] <= (gi == 0) ? ctr_reg : pipe_idx_reg[(gi == 0) ? 0 : gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr) begin
         mem_data[wr_ptr_reg[AW-1:0]] <= rdData;
         mem_idx[wr_ptr_reg[AW-1:0]]  <= pipe_idx_reg[RD_LAT-1];
      end
   end

   assign rA       = issue ? addr : ra_reg;
   assign outValid = !fifo_empty;
   assign outData  = outValid ? mem_data[rd_ptr_reg[AW-1:0]] : '0;
   assign outIdx   = outValid ? mem_idx[rd_ptr_reg[AW-1:0]] : '0;
   assign outFirst = outValid && (outIdx == '0);
   assign outLast  = outValid && (outIdx == LAST_IDX);
   assign busy     = (state_reg != IDLE);

   overflow_chk: assert property (@(posedge clk) disable iff (rst)
      !(wr && !pop && (fifo_count == DEPTH_W)));
endmodule

// File: tb/tb_fft_out_unload.sv
// Bench for fft_out_unload: natural and bit-reversed instances driven in lockstep,
// expected samples queued at frame issue and checked by a separate monitor.
module tb_fft_out_unload;
   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
   } exp_t;

   logic clk, rst, frameRdy, outReady;
   logic [3:0]  ra_v    [2];
   logic [31:0] data_v  [2];
   logic [3:0]  idx_v   [2];
   logic        valid_v [2];
   logic        first_v [2];
   logic        last_v  [2];
   logic        busy_v  [2];
   logic        done_v  [2];

   exp_t q0[$];
   exp_t q1[$];
   int   total, bad;
   int   done_cnt [2];
   int   acc_cnt  [2];
   logic exp_done [2];
   logic stall_chk [2];
   logic [31:0] held_data [2];
   logic [3:0]  held_idx  [2];
   logic pat_en, t4_arm;
   int   t4_phase;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         logic [3:0]  ra_w, idx_w;
         logic [31:0] rd_w, od_w, s1, s2, s3;
         logic        v_w, f_w, l_w, b_w, d_w;
         // Output buffer model: three register stages from rA to rdData.
         always @(posedge clk) begin
            s1 <= 32'(ra_w) * 32'd3;
            s2 <= s1;
            s3 <= s2;
         end
         assign rd_w = s3;
         fft_out_unload #(.LOGPTS(4), .DWIDTH(32), .RD_LAT(3), .BITREV(gi)) u_dut (
            .clk(clk), .rst(rst), .frameRdy(frameRdy), .rA(ra_w), .rdData(rd_w),
            .outData(od_w), .outValid(v_w), .outReady(outReady), .outFirst(f_w),
            .outLast(l_w), .outIdx(idx_w), .busy(b_w), .done(d_w));
         assign ra_v[gi]    = ra_w;
         assign data_v[gi]  = od_w;
         assign idx_v[gi]   = idx_w;
         assign valid_v[gi] = v_w;
         assign first_v[gi] = f_w;
         assign last_v[gi]  = l_w;
         assign busy_v[gi]  = b_w;
         assign done_v[gi]  = d_w;
      end
   endgenerate

   function automatic logic [3:0] bitrev4(input logic [3:0] v);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = v[3-i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         e.idx  = 4'(i);
         e.data = 32'(i) * 32'd3;
         q0.push_back(e);
         e.data = 32'(bitrev4(4'(i))) * 32'd3;
         q1.push_back(e);
      end
   endtask

   task automatic pulse();
      frameRdy = 1'b1;
      $display("frameRdy pulse at %0t", $time);
      tick();
      frameRdy = 1'b0;
   endtask

   task automatic wait_done(input int target);
      logic [3:0] pat;
      int n;
      pat = 4'b1001;
      n = 0;
      while (done_cnt[0] < target && n < 400) begin
         if (pat_en) outReady = pat[n % 4];
         tick();
         n++;
      end
      chk("done_reached", 32'(done_cnt[0] >= target), 32'd1);
      chk("done_pair", 32'(done_cnt[1]), 32'(done_cnt[0]));
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_valid"}, 32'(valid_v[k]), 32'd0);
         chk({tag, "_rA"}, 32'(ra_v[k]), 32'd0);
         chk({tag, "_busy"}, 32'(busy_v[k]), 32'd0);
         chk({tag, "_done"}, 32'(done_v[k]), 32'd0);
         chk({tag, "_data"}, data_v[k], 32'd0);
         chk({tag, "_idx"}, 32'(idx_v[k]), 32'd0);
         chk({tag, "_first"}, 32'(first_v[k]), 32'd0);
         chk({tag, "_last"}, 32'(last_v[k]), 32'd0);
      end
   endtask

   // Monitor: pops the scoreboard on each accepted sample, checks hold-while-stalled and done timing.
   always @(negedge clk) begin
      exp_t e;
      logic empty;
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            exp_done[k]  = 1'b0;
            stall_chk[k] = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            total++;
            if (done_v[k] !== exp_done[k]) begin
               bad++;
               $display("FAIL done[%0d] got=%0b want=%0b at %0t", k, done_v[k], exp_done[k], $time);
            end
            if (done_v[k]) done_cnt[k]++;
            exp_done[k] = 1'b0;
            if (stall_chk[k] && valid_v[k]) begin
               total++;
               if (data_v[k] !== held_data[k] || idx_v[k] !== held_idx[k]) begin
                  bad++;
                  $display("FAIL stable[%0d] got=%0d/%0d want=%0d/%0d", k, idx_v[k], data_v[k],
                           held_idx[k], held_data[k]);
               end
            end
            stall_chk[k] = 1'b0;
            if (valid_v[k]) begin
               if (outReady) begin
                  e = '0;
                  empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                  total++;
                  if (empty) begin
                     bad++;
                     $display("FAIL unexpected[%0d] got idx=%0d data=%0d want none", k, idx_v[k], data_v[k]);
                  end else begin
                     e = (k == 0) ? q0.pop_front() : q1.pop_front();
                     $display("accept[%0d] idx=%0d data=%0d first=%0b last=%0b", k, idx_v[k], data_v[k],
                              first_v[k], last_v[k]);
                     if (idx_v[k] !== e.idx || data_v[k] !== e.data ||
                         first_v[k] !== (e.idx == 4'd0) || last_v[k] !== (e.idx == 4'd15)) begin
                        bad++;
                        $display("FAIL sample[%0d] got idx=%0d data=%0d f=%0b l=%0b want idx=%0d data=%0d",
                                 k, idx_v[k], data_v[k], first_v[k], last_v[k], e.idx, e.data);
                     end
                     if (e.idx == 4'd15) exp_done[k] = 1'b1;
                  end
                  acc_cnt[k]++;
               end else begin
                  stall_chk[k] = 1'b1;
                  held_data[k] = data_v[k];
                  held_idx[k]  = idx_v[k];
               end
            end
         end
         if (t4_phase == 1) begin
            total++;
            if (ra_v[0] !== 4'd0 || ra_v[1] !== 4'd0 || busy_v[0] !== 1'b1) begin
               bad++;
               $display("FAIL t4_restart got rA=%0d/%0d busy=%0b want 0/0 1", ra_v[0], ra_v[1], busy_v[0]);
            end
            t4_phase = 2;
         end else if (t4_arm && t4_phase == 0 && done_v[0]) begin
            t4_phase = 1;
         end
      end
   end

   initial begin
      int n;
      int base;
      total = 0; bad = 0; t4_phase = 0; t4_arm = 1'b0; pat_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         done_cnt[k] = 0; acc_cnt[k] = 0; exp_done[k] = 1'b0; stall_chk[k] = 1'b0;
      end
      rst = 1'b0; frameRdy = 1'b0; outReady = 1'b1;
      #2 rst = 1'b1;
      #1 chk_zero("reset");
      tick(); tick();
      rst = 1'b0;
      tick();

      // T1/T2: straight frame, both read orders
      push_frame(); pulse(); wait_done(1);

      // T3: backpressure pattern 1,0,0,1
      pat_en = 1'b1; push_frame(); pulse(); wait_done(2);
      pat_en = 1'b0; outReady = 1'b1;
      tick();

      // T4: pulses at cycles 5 and 7 of a frame yield exactly one extra frame
      t4_arm = 1'b1;
      push_frame(); push_frame();
      pulse();
      repeat (4) tick();
      pulse();
      tick();
      pulse();
      wait_done(4);
      tick(); tick();
      chk("t4_seen", 32'(t4_phase), 32'd2);

      // T5: reset with six samples taken and the sink stalled
      push_frame(); pulse();
      base = acc_cnt[0];
      n = 0;
      while (acc_cnt[0] < base + 6 && n < 200) begin
         tick();
         n++;
      end
      chk("t5_six_taken", 32'(acc_cnt[0] - base), 32'd6);
      outReady = 1'b0;
      tick(); tick();
      #2 rst = 1'b1;
      #1 chk_zero("t5_async");
      q0.delete(); q1.delete();
      tick(); tick();
      rst = 1'b0;
      outReady = 1'b1;
      tick();
      chk("t5_no_done", 32'(done_cnt[0]), 32'd4);
      push_frame(); pulse(); wait_done(5);

      // T6: sink stalled from the start; issue stops at the FIFO credit
      outReady = 1'b0;
      push_frame(); pulse();
      repeat (20) tick();
      chk("t6_rA_nat", 32'(ra_v[0]), 32'd3);
      chk("t6_rA_rev", 32'(ra_v[1]), 32'd12);
      for (int k = 0; k < 2; k++) begin
         chk("t6_valid", 32'(valid_v[k]), 32'd1);
         chk("t6_idx", 32'(idx_v[k]), 32'd0);
         chk("t6_first", 32'(first_v[k]), 32'd1);
      end
      outReady = 1'b1;
      wait_done(6);

      tick(); tick();
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("final_busy", 32'(busy_v[0]), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
